// File: rtl/diff_demo_pkg.sv
// Shared types and constants for the psum sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package diff_demo_pkg;

   // Width of every dimension register and loop counter
   localparam int CNT_W = 8;

   // Row phase runs 0,1,2 and repeats
   localparam logic [1:0] COUNT3_MOD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   // Next row phase, wrapping at COUNT3_MOD
   function automatic logic [1:0] count3_next(input logic [1:0] c);
      return (c == (COUNT3_MOD - 2'd1)) ? 2'd0 : (c + 2'd1);
   endfunction

endpackage

// File: rtl/psum_seq_ctrl_if.sv
// Bundle of cfg / psum handshakes and guard-generator outputs of the psum sequencer.
// Latency: n/a (wires only).
// Backpressure: carries cfg_ready and psum_in_ready back to the producers.
interface psum_seq_ctrl_if;
   import diff_demo_pkg::*;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_w_num;
   logic [CNT_W-1:0] cfg_h_num;
   logic [CNT_W-1:0] cfg_c_num;
   logic             cfg_kernel_mode;

   logic             psum_in_valid;
   logic             psum_in_ready;
   logic             write_back_finish;

   logic             psum_almost_valid;
   logic [CNT_W-1:0] w_num;
   logic [CNT_W-1:0] h_num;
   logic             kernel_mode;
   logic [CNT_W-1:0] count_w;
   logic [CNT_W-1:0] count_h;
   logic [CNT_W-1:0] count_c;
   logic [1:0]       count_3;
   logic             is_even_row;
   logic             is_even_even_row;
   logic             busy;
   logic             layer_done;

   // Environment side: config source, PE array and guard generator
   modport master (
      output cfg_valid, cfg_w_num, cfg_h_num, cfg_c_num, cfg_kernel_mode,
      output psum_in_valid, write_back_finish,
      input  cfg_ready, psum_in_ready, psum_almost_valid,
      input  w_num, h_num, kernel_mode, count_w, count_h, count_c, count_3,
      input  is_even_row, is_even_even_row, busy, layer_done
   );

   // Sequencer side
   modport slave (
      input  cfg_valid, cfg_w_num, cfg_h_num, cfg_c_num, cfg_kernel_mode,
      input  psum_in_valid, write_back_finish,
      output cfg_ready, psum_in_ready, psum_almost_valid,
      output w_num, h_num, kernel_mode, count_w, count_h, count_c, count_3,
      output is_even_row, is_even_even_row, busy, layer_done
   );

endinterface

// File: rtl/nest_counter.sv
// Generic wrap counter: counts 0..max on en, wrap_o flags the enabled step at max.
// Latency: count updates one cycle after en; wrap_o is combinational from en.
// Backpressure: none; holds its value while en is low.
module nest_counter
   import diff_demo_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] max,
   output logic [W-1:0] cnt,
   output logic         wrap_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // An enabled step at the top value is the wrap; chained counters use it as their enable
   assign wrap_o = en && (cnt == max);

   // Count register: synchronous clear wins over a step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap_o ? '0 : (cnt + ONE);
      end
   end

endmodule

// File: rtl/psum_seq_ctrl.sv
// Sequences psum beats over a w x h x c layer and drives the guard generator.
// Latency: one cycle from beat acceptance to psum_almost_valid and its counters.
// Backpressure: psum_in_ready only in RUN, cfg_ready only in IDLE; all registered.
module psum_seq_ctrl
   import diff_demo_pkg::*;
#(
   parameter int MAX_DIM = 255
) (
   input  logic          clk,
   input  logic          rst,
   psum_seq_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] DIM_LIMIT = MAX_DIM[CNT_W-1:0];
   localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

   // Dimensions above the supported maximum are saturated rather than wrapped
   function automatic logic [CNT_W-1:0] clamp_dim(input logic [CNT_W-1:0] d);
      return (d > DIM_LIMIT) ? DIM_LIMIT : d;
   endfunction

   seq_state_t       state;
   seq_state_t       state_d;
   logic             zero_pend;
   logic             zero_pend_d;

   logic             cfg_acc;
   logic             cfg_zero;
   logic             beat;
   logic [CNT_W-1:0] c_num_r;

   logic [CNT_W-1:0] w_max;
   logic [CNT_W-1:0] h_max;
   logic [CNT_W-1:0] c_max;
   logic [CNT_W-1:0] cw;
   logic [CNT_W-1:0] ch;
   logic [CNT_W-1:0] cc;
   logic             w_wrap;
   logic             h_wrap;
   logic             final_beat;

   logic [1:0]       row3;
   logic             row_even;
   logic             row_ee;

   // cfg_ready is registered and only high in IDLE, so it qualifies acceptance on its own
   assign cfg_acc  = bus.cfg_valid && bus.cfg_ready;
   assign cfg_zero = (bus.cfg_w_num == '0) || (bus.cfg_h_num == '0) || (bus.cfg_c_num == '0);
   assign beat     = bus.psum_in_valid && bus.psum_in_ready;

   assign w_max = bus.w_num - ONE;
   assign h_max = bus.h_num - ONE;
   assign c_max = c_num_r - ONE;

   // Internal counters hold the position of the next beat; w steps on every beat,
   // h on each w wrap, c on each h wrap, and the c wrap is the last beat of the layer
   nest_counter #(.W(CNT_W)) u_cnt_w (
      .clk    (clk),
      .rst    (rst),
      .clr    (cfg_acc),
      .en     (beat),
      .max    (w_max),
      .cnt    (cw),
      .wrap_o (w_wrap)
   );

   nest_counter #(.W(CNT_W)) u_cnt_h (
      .clk    (clk),
      .rst    (rst),
      .clr    (cfg_acc),
      .en     (w_wrap),
      .max    (h_max),
      .cnt    (ch),
      .wrap_o (h_wrap)
   );

   nest_counter #(.W(CNT_W)) u_cnt_c (
      .clk    (clk),
      .rst    (rst),
      .clr    (cfg_acc),
      .en     (h_wrap),
      .max    (c_max),
      .cnt    (cc),
      .wrap_o (final_beat)
   );

   // Layer configuration captured on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.w_num       <= '0;
         bus.h_num       <= '0;
         c_num_r         <= '0;
         bus.kernel_mode <= 1'b0;
      end else if (cfg_acc) begin
         bus.w_num       <= clamp_dim(bus.cfg_w_num);
         bus.h_num       <= clamp_dim(bus.cfg_h_num);
         c_num_r         <= clamp_dim(bus.cfg_c_num);
         bus.kernel_mode <= bus.cfg_kernel_mode;
      end
   end

   // Row phase of the next beat: advances on each row step, restarts with every channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row3     <= 2'd0;
         row_even <= 1'b0;
         row_ee   <= 1'b0;
      end else if (cfg_acc) begin
         row3     <= 2'd0;
         row_even <= 1'b0;
         row_ee   <= 1'b0;
      end else if (w_wrap) begin
         if (h_wrap) begin
            row3     <= 2'd0;
            row_even <= 1'b0;
            row_ee   <= 1'b0;
         end else begin
            row3     <= count3_next(row3);
            row_even <= ~row_even;
            // leaving an odd row completes a pair of rows
            if (row_even) begin
               row_ee <= ~row_ee;
            end
         end
      end
   end

   // Beat strobe plus a snapshot of the accepted beat's position; held between beats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.psum_almost_valid <= 1'b0;
         bus.count_w           <= '0;
         bus.count_h           <= '0;
         bus.count_c           <= '0;
         bus.count_3           <= 2'd0;
         bus.is_even_row       <= 1'b0;
         bus.is_even_even_row  <= 1'b0;
      end else begin
         bus.psum_almost_valid <= beat;
         if (cfg_acc) begin
            bus.count_w          <= '0;
            bus.count_h          <= '0;
            bus.count_c          <= '0;
            bus.count_3          <= 2'd0;
            bus.is_even_row      <= 1'b0;
            bus.is_even_even_row <= 1'b0;
         end else if (beat) begin
            bus.count_w          <= cw;
            bus.count_h          <= ch;
            bus.count_c          <= cc;
            bus.count_3          <= row3;
            bus.is_even_row      <= row_even;
            bus.is_even_even_row <= row_ee;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         zero_pend <= 1'b0;
      end else begin
         state     <= state_d;
         zero_pend <= zero_pend_d;
      end
   end

   // Next state; an empty layer is parked for one cycle in IDLE with cfg_ready low,
   // then reported through DONE without ever entering RUN
   always_comb begin
      state_d     = state;
      zero_pend_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (zero_pend) begin
               state_d = ST_DONE;
            end else if (cfg_acc) begin
               if (cfg_zero) begin
                  zero_pend_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // a write-back finish coinciding with the last beat skips DRAIN
            if (final_beat) begin
               state_d = bus.write_back_finish ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.write_back_finish) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they line up with the state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.cfg_ready     <= 1'b0;
         bus.psum_in_ready <= 1'b0;
         bus.busy          <= 1'b0;
         bus.layer_done    <= 1'b0;
      end else begin
         bus.cfg_ready     <= (state_d == ST_IDLE) && !zero_pend_d;
         bus.psum_in_ready <= (state_d == ST_RUN);
         bus.busy          <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         bus.layer_done    <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Directed bench for psum_seq_ctrl: table of layers plus reset / idle corner cases.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: psum beats are only offered while psum_in_ready is expected high.
module tb_psum_seq_ctrl;

   logic clk = 1'b0;
   logic rst;

   psum_seq_ctrl_if bus();

   psum_seq_ctrl #(.MAX_DIM(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int strobes = 0;

   typedef struct {
      logic [7:0] w;
      logic [7:0] h;
      logic [7:0] c;
      logic       km;
      bit         gaps;
      bit         wbf_same;
      int         n_beats;
      logic [7:0] lw;
      logic [7:0] lh;
      logic [7:0] lc;
      logic [1:0] l3;
      logic       ler;
      logic       leer;
   } layer_vec_t;

   layer_vec_t vecs [8];
   layer_vec_t post_rst_vec;

   // Strobes are tallied away from the active edge
   always @(negedge clk) begin
      if (bus.psum_almost_valid === 1'b1) strobes <= strobes + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dut_tuple();
      return {4'h0, bus.count_w, bus.count_h, bus.count_c, bus.count_3,
              bus.is_even_row, bus.is_even_even_row};
   endfunction

   // Expected position of beat k in a w x h x c layer
   function automatic logic [31:0] model_tuple(input int w, input int h, input int k);
      int cw;
      int ch;
      int cc;
      int c3;
      cw = k % w;
      ch = (k / w) % h;
      cc = k / (w * h);
      c3 = ch % 3;
      return {4'h0, cw[7:0], ch[7:0], cc[7:0], c3[1:0], ch[0], ch[1]};
   endfunction

   task automatic run_layer(input layer_vec_t v);
      int         sent;
      int         cyc;
      int         s0;
      logic       vld;
      logic [31:0] exp_t;
      sent = 0;
      cyc  = 0;
      s0   = strobes;
      bus.cfg_w_num       = v.w;
      bus.cfg_h_num       = v.h;
      bus.cfg_c_num       = v.c;
      bus.cfg_kernel_mode = v.km;
      bus.cfg_valid       = 1'b1;
      chk("cfg_ready_idle", bus.cfg_ready, 1);
      step();
      bus.cfg_valid = 1'b0;
      if (v.n_beats == 0) begin
         chk("zero_c1_done", bus.layer_done, 0);
         chk("zero_c1_busy", bus.busy, 0);
         chk("zero_c1_cfg_ready", bus.cfg_ready, 0);
         chk("zero_c1_ready", bus.psum_in_ready, 0);
         step();
         chk("zero_c2_done", bus.layer_done, 1);
         step();
         chk("zero_done_pulse", bus.layer_done, 0);
         chk("zero_back_idle", bus.cfg_ready, 1);
         chk("zero_no_strobes", strobes - s0, 0);
      end else begin
         chk("run_busy", bus.busy, 1);
         chk("run_ready", bus.psum_in_ready, 1);
         chk("w_num", bus.w_num, v.w);
         chk("h_num", bus.h_num, v.h);
         chk("kernel_mode", bus.kernel_mode, v.km);
         chk("cleared_tuple", dut_tuple(), 0);
         while (sent < v.n_beats && cyc < 1000) begin
            vld = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            chk("ready_in_run", bus.psum_in_ready, 1);
            bus.psum_in_valid = vld;
            bus.write_back_finish = vld && (v.wbf_same ? (sent == v.n_beats - 1)
                                                       : (sent == 0 && v.n_beats > 1));
            if (sent == 1) begin
               bus.cfg_valid = 1'b1;
               bus.cfg_w_num = 8'd77;
            end else begin
               bus.cfg_valid = 1'b0;
            end
            step();
            cyc++;
            chk("strobe", bus.psum_almost_valid, vld);
            if (vld) begin
               chk("beat_tuple", dut_tuple(), model_tuple(v.w, v.h, sent));
               sent++;
            end else begin
               exp_t = (sent == 0) ? 32'h0 : model_tuple(v.w, v.h, sent - 1);
               chk("gap_hold", dut_tuple(), exp_t);
            end
         end
         bus.psum_in_valid     = 1'b0;
         bus.write_back_finish = 1'b0;
         bus.cfg_valid         = 1'b0;
         chk("beat_budget", sent, v.n_beats);
         chk("ready_drop", bus.psum_in_ready, 0);
         chk("last_tuple", dut_tuple(), {4'h0, v.lw, v.lh, v.lc, v.l3, v.ler, v.leer});
         chk("w_num_kept", bus.w_num, v.w);
         if (v.wbf_same) begin
            chk("done_same_cycle", bus.layer_done, 1);
         end else begin
            chk("drain_busy", bus.busy, 1);
            chk("drain_not_done", bus.layer_done, 0);
            repeat (4) begin
               step();
               chk("drain_wait", bus.layer_done, 0);
            end
            bus.write_back_finish = 1'b1;
            step();
            bus.write_back_finish = 1'b0;
            chk("done_after_wbf", bus.layer_done, 1);
         end
         chk("done_not_busy", bus.busy, 0);
         step();
         chk("done_pulse", bus.layer_done, 0);
         chk("back_idle", bus.cfg_ready, 1);
         chk("strobe_count", strobes - s0, v.n_beats);
      end
   endtask

   initial begin
      //          w     h     c     km    gaps  same  n   lw    lh    lc    l3    er    eer
      vecs[0] = '{8'd4, 8'd3, 8'd2, 1'b1, 1'b0, 1'b0, 24, 8'd3, 8'd2, 8'd1, 2'd2, 1'b0, 1'b1};
      vecs[1] = '{8'd2, 8'd6, 8'd1, 1'b0, 1'b0, 1'b1, 12, 8'd1, 8'd5, 8'd0, 2'd2, 1'b1, 1'b0};
      vecs[2] = '{8'd3, 8'd2, 8'd1, 1'b1, 1'b1, 1'b0,  6, 8'd2, 8'd1, 8'd0, 2'd1, 1'b1, 1'b0};
      vecs[3] = '{8'd1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1,  1, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
      vecs[4] = '{8'd5, 8'd4, 8'd3, 1'b1, 1'b1, 1'b1, 60, 8'd4, 8'd3, 8'd2, 2'd0, 1'b1, 1'b1};
      vecs[5] = '{8'd4, 8'd0, 8'd2, 1'b1, 1'b0, 1'b0,  0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
      vecs[6] = '{8'd0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b0,  0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
      vecs[7] = '{8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0,  0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0};
      post_rst_vec = '{8'd2, 8'd2, 8'd1, 1'b1, 1'b0, 1'b0, 4, 8'd1, 8'd1, 8'd0, 2'd1, 1'b1, 1'b0};

      rst                   = 1'b1;
      bus.cfg_valid         = 1'b0;
      bus.cfg_w_num         = 8'd0;
      bus.cfg_h_num         = 8'd0;
      bus.cfg_c_num         = 8'd0;
      bus.cfg_kernel_mode   = 1'b0;
      bus.psum_in_valid     = 1'b0;
      bus.write_back_finish = 1'b0;

      repeat (2) step();
      chk("rst_cfg_ready", bus.cfg_ready, 0);
      chk("rst_psum_ready", bus.psum_in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_layer_done", bus.layer_done, 0);
      chk("rst_strobe", bus.psum_almost_valid, 0);
      chk("rst_tuple", dut_tuple(), 0);
      chk("rst_w_num", bus.w_num, 0);
      rst = 1'b0;
      step();
      chk("rel_cfg_ready", bus.cfg_ready, 1);
      chk("rel_strobe", bus.psum_almost_valid, 0);

      // write-back finish while idle must not produce a layer_done
      bus.write_back_finish = 1'b1;
      step();
      bus.write_back_finish = 1'b0;
      chk("idle_wbf_done", bus.layer_done, 0);
      chk("idle_wbf_busy", bus.busy, 0);
      step();
      chk("idle_wbf_done2", bus.layer_done, 0);

      for (int i = 0; i < 8; i++) run_layer(vecs[i]);

      // reset in the middle of a 4x4x1 layer, after the seventh beat
      bus.cfg_w_num       = 8'd4;
      bus.cfg_h_num       = 8'd4;
      bus.cfg_c_num       = 8'd1;
      bus.cfg_kernel_mode = 1'b1;
      bus.cfg_valid       = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.psum_in_valid = 1'b1;
         step();
      end
      chk("pre_rst_tuple", dut_tuple(), model_tuple(4, 4, 6));
      chk("pre_rst_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_strobe", bus.psum_almost_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ready", bus.psum_in_ready, 0);
      chk("mid_rst_cfg_ready", bus.cfg_ready, 0);
      chk("mid_rst_tuple", dut_tuple(), 0);
      chk("mid_rst_w_num", bus.w_num, 0);
      chk("mid_rst_km", bus.kernel_mode, 0);
      step();
      step();
      chk("held_rst_cfg_ready", bus.cfg_ready, 0);
      rst = 1'b0;
      step();
      chk("post_rst_cfg_ready", bus.cfg_ready, 1);
      chk("post_rst_strobe", bus.psum_almost_valid, 0);
      bus.psum_in_valid = 1'b0;
      run_layer(post_rst_vec);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule

// File: doc/psum_seq_ctrl.md
PSUM_SEQ_CTRL -- requirements
Module: psum_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIM, default 255, meaning the maximum value accepted for w_num, h_num and c_num.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have cfg_valid/cfg_ready, input/output, 1 bit each: layer-configuration handshake.
REQ-005 SHALL have cfg_w_num, cfg_h_num, cfg_c_num, inputs, 8 bits each: feature-map width, height and input-channel count.
REQ-006 SHALL have cfg_kernel_mode, input, 1 bit: kernel mode, captured with the configuration.
REQ-007 SHALL have psum_in_valid/psum_in_ready, input/output, 1 bit each: per-beat psum handshake from the PE array.
REQ-008 SHALL have write_back_finish, input, 1 bit: pulse from the guard generator when write-back completes.
REQ-009 SHALL have psum_almost_valid, output, 1 bit: beat strobe to the guard generator.
REQ-010 SHALL have the following outputs to the guard generator: w_num, h_num, kernel_mode, count_w, count_h, count_c, count_3 (2 bits), is_even_row, is_even_even_row.
REQ-011 SHALL have busy and layer_done, outputs, 1 bit each.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE: cfg_ready=1; on cfg_valid, register the configuration, clear all counters and go to RUN.
REQ-014 A configuration with any of w/h/c equal to 0 SHALL be accepted, SHALL not enter RUN, and SHALL go directly to DONE.
REQ-015 RUN: psum_in_ready=1; a beat is accepted when psum_in_valid&psum_in_ready.
REQ-016 Each accepted beat SHALL register psum_almost_valid=1 for exactly one cycle, together with the counters of that beat (latency 1, all outputs registered).
REQ-017 Counter order: count_w runs 0..w_num-1; it wraps to 0 and increments count_h; count_h wraps at h_num-1 and increments count_c; count_c runs 0..c_num-1.
REQ-018 Row state on each count_h increment: count_3 advances 0,1,2,0 and is_even_row toggles; is_even_even_row toggles every second row (sequence 0,0,1,1,...). All three clear when count_h wraps.
REQ-019 Reset/first-row values SHALL be count_3=0, is_even_row=0, is_even_even_row=0.
REQ-020 On acceptance of the final beat (w_num-1, h_num-1, c_num-1), the FSM SHALL go to DRAIN and psum_in_ready SHALL drop in the following cycle.
REQ-021 DRAIN: psum_in_ready=0; on write_back_finish go to DONE.
REQ-022 If write_back_finish arrives in the same cycle as the final-beat acceptance, it SHALL be honoured and the FSM SHALL go to DONE directly.
REQ-023 DONE: layer_done=1 for one cycle, then go to IDLE.
REQ-024 busy SHALL be 1 in RUN and DRAIN.
REQ-025 cfg_valid outside IDLE SHALL be ignored (cfg_ready=0).
REQ-026 write_back_finish outside DRAIN and the final-beat cycle SHALL be ignored.
REQ-027 psum_in_valid deasserted SHALL hold all counters, and psum_almost_valid SHALL be 0.
REQ-028 Counters SHALL be 8 bits; comparisons use registered nums minus 1, with no wrap beyond the configured values.

Reset
REQ-029 rst SHALL force IDLE asynchronously, including mid-layer.
REQ-030 Under reset, all counters, psum_almost_valid, layer_done, busy, psum_in_ready and the registered configuration SHALL be 0, and cfg_ready SHALL be 0 while rst is high.
REQ-031 After rst deasserts, cfg_ready=1 on the next cycle and no stale psum_almost_valid SHALL be issued.

Structure
REQ-032 The FSM state enum type and the count_3 modulus constant SHALL live in diff_demo_pkg.
REQ-033 The block SHALL contain one sub-module, nest_counter: a generic wrap counter with en, max, wrap_o, instantiated three times (w, h, c).

Verification
REQ-034 Scenario: cfg w=4,h=3,c=2, kernel_mode=1, psum_in_valid held 1 -> 24 psum_almost_valid pulses; count_h sequence 0,1,2 per channel; count_3 0,1,2; is_even_row 0,1,0; DRAIN is entered after beat 24.
REQ-035 Scenario: w=2,h=6,c=1 -> is_even_even_row sequence over rows is 0,0,1,1,0,0; count_3 sequence is 0,1,2,0,1,2.
REQ-036 Scenario: random psum_in_valid gaps with w=3,h=2,c=1 -> exactly 6 strobes, counters held during gaps, no duplicate tuples.
REQ-037 Scenario: write_back_finish in the same cycle as the final beat -> layer_done the next cycle; write_back_finish 5 cycles later instead -> layer_done exactly 1 cycle after it.
REQ-038 Scenario: rst asserted at beat 7 of w=4,h=4,c=1 -> outputs 0 immediately; a new cfg is accepted after release and restarts at (0,0,0).
REQ-039 Scenario: cfg with h=0 -> no strobes, and layer_done occurs 2 cycles after cfg acceptance.
